// File: rtl/gen_trafico_pcie.sv
// Programmable push/pop burst generator for the PCIe transaction-layer FIFO block.
// Define GEN_CNT_EN to add saturating push_cnt/pop_cnt strobe counters.
module gen_trafico_pcie #(
    parameter int DATA_W    = 6,
    parameter int NUM_VC    = 2,
    parameter int NUM_DEST  = 2,
    parameter int BURST_LEN = 4,
    parameter int POP_LEN   = 4,
    parameter int INIT_CYC  = 1,
    parameter int LFSR_SEED = 4'hA
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              start,
    input  logic              mode,
    input  logic              Pausa_MF,
    input  logic              error_out,
    output logic              init,
    output logic              push,
    output logic              pop,
    output logic [DATA_W-1:0] data_in_principal,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef GEN_CNT_EN
    ,
    output logic [15:0]       push_cnt,
    output logic [15:0]       pop_cnt
`endif
);

    localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int DEST_W = (NUM_DEST > 1) ? $clog2(NUM_DEST) : 1;
    localparam int PAY_W  = DATA_W - VC_W - DEST_W;

    localparam logic [PAY_W-1:0]  SEED     = PAY_W'(LFSR_SEED);
    localparam logic [7:0]        BURST_L  = 8'(BURST_LEN);
    localparam logic [7:0]        POP_L    = 8'(POP_LEN);
    localparam logic [3:0]        INIT_L   = 4'(INIT_CYC);
    localparam logic [DEST_W-1:0] DEST_MAX = DEST_W'(NUM_DEST - 1);
    localparam logic [VC_W-1:0]   VC_MAX   = VC_W'(NUM_VC - 1);

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_PUSH = 3'd2;
    localparam logic [2:0] S_POP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [3:0]        init_cnt_q, init_cnt_d;
    logic [7:0]        k_q, k_d;
    logic [7:0]        popped_q, popped_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [VC_W-1:0]   vc_q, vc_d;
    logic [PAY_W-1:0]  lfsr_q, lfsr_d;
    logic              mode_q, mode_d;
    logic              init_q, init_d;
    logic              push_q, push_d;
    logic              pop_q, pop_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [PAY_W-1:0]  lfsr_next;
    logic [PAY_W-1:0]  payload;

    // Fibonacci shift with feedback from the two top bits (x^4+x^3+1 for a 4-bit payload)
    assign lfsr_next = {lfsr_q[PAY_W-2:0], lfsr_q[PAY_W-1] ^ lfsr_q[PAY_W-2]};
    assign payload   = mode_q ? PAY_W'(k_q) : lfsr_q;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        k_d        = k_q;
        popped_d   = popped_q;
        dest_d     = dest_q;
        vc_d       = vc_q;
        lfsr_d     = lfsr_q;
        mode_d     = mode_q;
        init_d     = 1'b0;
        push_d     = 1'b0;
        pop_d      = 1'b0;
        data_d     = data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        case (state_q)
            S_INIT: begin
                if (init_cnt_q < INIT_L) begin
                    init_d     = 1'b1;
                    init_cnt_d = init_cnt_q + 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (start) begin
                    state_d = S_PUSH;
                    busy_d  = 1'b1;
                    k_d     = '0;
                    dest_d  = '0;
                    vc_d    = '0;
                    lfsr_d  = SEED;
                    mode_d  = mode;
                end
            end
            S_PUSH: begin
                if (k_q == BURST_L) begin
                    data_d = '0;
                    if (POP_LEN == 0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_POP;
                        pop_d    = 1'b1;
                        popped_d = 8'd1;
                    end
                end else if (!Pausa_MF) begin
                    push_d = 1'b1;
                    data_d = {vc_q, dest_q, payload};
                    k_d    = k_q + 8'd1;
                    if (!mode_q) begin
                        lfsr_d = lfsr_next;
                    end
                    // dest cycles fastest; vc advances each time dest wraps
                    if (dest_q == DEST_MAX) begin
                        dest_d = '0;
                        vc_d   = (vc_q == VC_MAX) ? '0 : vc_q + 1'b1;
                    end else begin
                        dest_d = dest_q + 1'b1;
                    end
                end
            end
            S_POP: begin
                if (popped_q == POP_L) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    pop_d    = 1'b1;
                    popped_d = popped_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase

        if (error_out && (state_q != S_INIT)) begin
            state_d = S_ERR;
            push_d  = 1'b0;
            pop_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            k_q        <= '0;
            popped_q   <= '0;
            dest_q     <= '0;
            vc_q       <= '0;
            lfsr_q     <= SEED;
            mode_q     <= 1'b0;
            init_q     <= 1'b0;
            push_q     <= 1'b0;
            pop_q      <= 1'b0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            k_q        <= k_d;
            popped_q   <= popped_d;
            dest_q     <= dest_d;
            vc_q       <= vc_d;
            lfsr_q     <= lfsr_d;
            mode_q     <= mode_d;
            init_q     <= init_d;
            push_q     <= push_d;
            pop_q      <= pop_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign init              = init_q;
    assign push              = push_q;
    assign pop               = pop_q;
    assign data_in_principal = data_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;

`ifdef GEN_CNT_EN
    logic [15:0] push_cnt_q;
    logic [15:0] pop_cnt_q;

    // Counts track the strobes as they are registered, saturating at all-ones
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
        end else begin
            if (push_d && (push_cnt_q != 16'hFFFF)) begin
                push_cnt_q <= push_cnt_q + 16'd1;
            end
            if (pop_d && (pop_cnt_q != 16'hFFFF)) begin
                pop_cnt_q <= pop_cnt_q + 16'd1;
            end
        end
    end

    assign push_cnt = push_cnt_q;
    assign pop_cnt  = pop_cnt_q;
`endif

endmodule

// File: tb/tb_gen_trafico_pcie.sv
// Randomised bench for gen_trafico_pcie: default, wide (4 VC x 4 dest) and no-pop builds
// checked against a phase-level reference model of the burst sequence.
module tb_gen_trafico_pcie;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_L   = 1'b1;
    logic       mode      = 1'b0;
    logic       Pausa_MF  = 1'b0;
    logic       error_out = 1'b0;
    logic [2:0] start_v   = 3'b000;

    logic       init_m, push_m, pop_m, busy_m, done_m, err_m;
    logic [5:0] data_m;
    logic       init_w, push_w, pop_w, busy_w, done_w, err_w;
    logic [7:0] data_w;
    logic       init_n, push_n, pop_n, busy_n, done_n, err_n;
    logic [5:0] data_n;
`ifdef GEN_CNT_EN
    logic [15:0] push_cnt_m, pop_cnt_m, push_cnt_w, pop_cnt_w, push_cnt_n, pop_cnt_n;
`endif

    gen_trafico_pcie u_main (
        .clk(clk), .reset_L(reset_L), .start(start_v[0]), .mode(mode),
        .Pausa_MF(Pausa_MF), .error_out(error_out),
        .init(init_m), .push(push_m), .pop(pop_m), .data_in_principal(data_m),
        .busy(busy_m), .done(done_m), .err(err_m)
`ifdef GEN_CNT_EN
        , .push_cnt(push_cnt_m), .pop_cnt(pop_cnt_m)
`endif
    );

    gen_trafico_pcie #(.DATA_W(8), .NUM_VC(4), .NUM_DEST(4), .BURST_LEN(16)) u_wide (
        .clk(clk), .reset_L(reset_L), .start(start_v[1]), .mode(mode),
        .Pausa_MF(Pausa_MF), .error_out(error_out),
        .init(init_w), .push(push_w), .pop(pop_w), .data_in_principal(data_w),
        .busy(busy_w), .done(done_w), .err(err_w)
`ifdef GEN_CNT_EN
        , .push_cnt(push_cnt_w), .pop_cnt(pop_cnt_w)
`endif
    );

    gen_trafico_pcie #(.POP_LEN(0)) u_nopop (
        .clk(clk), .reset_L(reset_L), .start(start_v[2]), .mode(mode),
        .Pausa_MF(Pausa_MF), .error_out(error_out),
        .init(init_n), .push(push_n), .pop(pop_n), .data_in_principal(data_n),
        .busy(busy_n), .done(done_n), .err(err_n)
`ifdef GEN_CNT_EN
        , .push_cnt(push_cnt_n), .pop_cnt(pop_cnt_n)
`endif
    );

    // Observed outputs of the instance currently under test
    int         sel = 0;
    logic       o_init, o_push, o_pop, o_busy, o_done, o_err;
    logic [7:0] o_data;

    always_comb begin
        o_init = init_m; o_push = push_m; o_pop = pop_m;
        o_busy = busy_m; o_done = done_m; o_err = err_m;
        o_data = {2'b00, data_m};
        if (sel == 1) begin
            o_init = init_w; o_push = push_w; o_pop = pop_w;
            o_busy = busy_w; o_done = done_w; o_err = err_w;
            o_data = data_w;
        end else if (sel == 2) begin
            o_init = init_n; o_push = push_n; o_pop = pop_n;
            o_busy = busy_n; o_done = done_n; o_err = err_n;
            o_data = {2'b00, data_n};
        end
    end

    int checks = 0;
    int errors = 0;
    int exp_push_m = 0;
    int exp_pop_m  = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: payload LFSR value after j issued words, from seed 4'hA
    function automatic int lfsr_at(input int j, input int payw);
        int v;
        v = 'hA;
        for (int i = 0; i < j; i++) begin
            v = ((v << 1) | (((v >> (payw - 1)) ^ (v >> (payw - 2))) & 1)) & ((1 << payw) - 1);
        end
        return v;
    endfunction

    function automatic int word_at(input int j, input bit md, input int nd, input int nvc,
                                   input int destw, input int payw);
        int pay;
        pay = md ? (j % (1 << payw)) : lfsr_at(j, payw);
        return (((j / nd) % nvc) << (payw + destw)) | ((j % nd) << payw) | pay;
    endfunction

    task automatic do_reset(input int s);
        sel = s;
        reset_L = 1'b0;
        #1;
        check_val("rst_init", o_init, 0);
        check_val("rst_push", o_push, 0);
        check_val("rst_pop",  o_pop,  0);
        check_val("rst_busy", o_busy, 0);
        check_val("rst_done", o_done, 0);
        check_val("rst_err",  o_err,  0);
        check_val("rst_data", o_data, 0);
        exp_push_m = 0;
        exp_pop_m  = 0;
`ifdef GEN_CNT_EN
        check_val("rst_push_cnt", push_cnt_m, 0);
        check_val("rst_pop_cnt",  pop_cnt_m,  0);
`endif
        @(negedge clk);
        reset_L = 1'b1;
        @(posedge clk); #1;
        check_val("init_high", o_init, 1);
        @(posedge clk); #1;
        check_val("init_low", o_init, 0);
        $display("reset sel=%0d done", s);
    endtask

    task automatic run_check(input int s, input bit md, input int burst, input int poplen,
                             input int nd, input int nvc, input int destw, input int payw,
                             input int pause_pct);
        int j;
        int exp;
        int stalls;
        logic [7:0] held;
        logic p;
        j = 0; stalls = 0; held = 8'h00;
        sel = s;
        @(negedge clk);
        mode = md;
        start_v[s] = 1'b1;
        Pausa_MF = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        check_val("start_busy", o_busy, 1);
        check_val("start_push", o_push, 0);
        while (j < burst) begin
            @(negedge clk);
            p = ($urandom_range(0, 99) < pause_pct);
            Pausa_MF = p;
            mode = 1'($urandom_range(0, 1));
            start_v[s] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            if (p) begin
                check_val("stall_push", o_push, 0);
                check_val("stall_data", o_data, held);
                stalls++;
            end else begin
                exp = word_at(j, md, nd, nvc, destw, payw);
                check_val("push", o_push, 1);
                check_val("word", o_data, exp);
                if (!md) begin
                    check_val("lfsr_nonzero", ((o_data & 8'((1 << payw) - 1)) != 0), 1);
                end
                held = 8'(exp);
                j++;
                if (s == 0) exp_push_m++;
            end
            check_val("push_pop_excl", o_pop, 0);
            check_val("push_busy", o_busy, 1);
            check_val("push_done", o_done, 0);
        end
        @(negedge clk);
        start_v[s] = 1'b0;
        Pausa_MF = 1'($urandom_range(0, 1));
        for (int i = 0; i < poplen; i++) begin
            @(posedge clk); #1;
            check_val("pop", o_pop, 1);
            check_val("pop_push", o_push, 0);
            check_val("pop_data", o_data, 0);
            check_val("pop_busy", o_busy, 1);
            if (s == 0) exp_pop_m++;
            @(negedge clk);
            Pausa_MF = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        check_val("done", o_done, 1);
        check_val("done_pop", o_pop, 0);
        check_val("done_push", o_push, 0);
        check_val("done_busy", o_busy, 1);
        check_val("done_data", o_data, 0);
        @(posedge clk); #1;
        check_val("after_done", o_done, 0);
        check_val("after_busy", o_busy, 0);
        Pausa_MF = 1'b0;
        $display("run sel=%0d mode=%0d burst=%0d pop=%0d stalls=%0d", s, md, burst, poplen, stalls);
    endtask

    initial begin
        #2;
        do_reset(0);

        // default build: clean run, stalled runs, LFSR runs, random mixes
        run_check(0, 1'b1, 4, 4, 2, 2, 1, 4, 0);
        run_check(0, 1'b1, 4, 4, 2, 2, 1, 4, 40);
        run_check(0, 1'b0, 4, 4, 2, 2, 1, 4, 0);
        for (int r = 0; r < 5; r++) begin
            run_check(0, 1'($urandom_range(0, 1)), 4, 4, 2, 2, 1, 4, 30);
        end
`ifdef GEN_CNT_EN
        check_val("push_cnt", push_cnt_m, exp_push_m);
        check_val("pop_cnt",  pop_cnt_m,  exp_pop_m);
`endif

        // error during the third push cycle; ERR is sticky until reset
        sel = 0;
        @(negedge clk);
        mode = 1'b1; Pausa_MF = 1'b0; start_v[0] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("err_pre_push", o_push, 1);
        check_val("err_pre_word", o_data, word_at(2, 1'b1, 2, 2, 1, 4));
        @(negedge clk);
        error_out = 1'b1;
        @(posedge clk); #1;
        check_val("err_push", o_push, 0);
        check_val("err_flag", o_err, 1);
        check_val("err_busy", o_busy, 0);
        check_val("err_pop",  o_pop,  0);
        @(negedge clk);
        error_out = 1'b0;
        start_v[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_val("err_start_busy", o_busy, 0);
            check_val("err_start_push", o_push, 0);
            check_val("err_sticky", o_err, 1);
        end
        @(negedge clk);
        start_v[0] = 1'b0;
        $display("error scenario done");
        do_reset(0);

        // wide build: every VC/dest pair once per burst
        run_check(1, 1'b1, 16, 4, 4, 4, 2, 4, 0);
        run_check(1, 1'($urandom_range(0, 1)), 16, 4, 4, 4, 2, 4, 25);

        // asynchronous reset in the middle of a wide burst
        sel = 1;
        @(negedge clk);
        mode = 1'b1; Pausa_MF = 1'b0; start_v[1] = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        start_v[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("midrst_pre_push", o_push, 1);
        #1;
        do_reset(1);

        // no-pop build: done follows the last push directly
        run_check(2, 1'b1, 4, 0, 2, 2, 1, 4, 0);
        run_check(2, 1'($urandom_range(0, 1)), 4, 0, 2, 2, 1, 4, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
